// File: rtl/input_frontend_if.sv
// rtl/input_frontend_if.sv - pin-side and CPU-side signal bundle for input_frontend
interface input_frontend_if #(
    parameter int CHANNELS = 8
);
    logic [CHANNELS-1:0]   sig_i;
    logic [2*CHANNELS-1:0] edge_mode;
    logic [CHANNELS-1:0]   clear_i;
    logic [CHANNELS-1:0]   level_o;
    logic [CHANNELS-1:0]   pulse_o;
    logic [CHANNELS-1:0]   event_o;
    logic [CHANNELS-1:0]   capture_o;
    logic                  capture_valid;

    modport master (
        output sig_i, edge_mode, clear_i,
        input  level_o, pulse_o, event_o, capture_o, capture_valid
    );

    modport slave (
        input  sig_i, edge_mode, clear_i,
        output level_o, pulse_o, event_o, capture_o, capture_valid
    );
endinterface

// File: rtl/input_frontend.sv
// rtl/input_frontend.sv - per-channel synchroniser, debouncer, edge qualifier, sticky flags and snapshot
module input_frontend #(
    parameter int                  CHANNELS        = 8,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 1_500_000,
    parameter logic [CHANNELS-1:0] INIT_LEVEL      = '0,
    parameter int                  CAPTURE_CH      = 0
) (
    input  logic               clk,
    input  logic               reset,
    input_frontend_if.slave    bus
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CW-1:0]       r_cnt [CHANNELS];
    logic [CW-1:0]       w_cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] r_level;
    logic [CHANNELS-1:0] r_pulse;
    logic [CHANNELS-1:0] r_event;
    logic [CHANNELS-1:0] r_capture;
    logic                r_capture_valid;
    logic [CHANNELS-1:0] w_sync;
    logic [CHANNELS-1:0] w_level_nxt;
    logic [CHANNELS-1:0] w_pulse_nxt;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Counter runs only while the synchronised value disagrees with the accepted level,
    // so any bounce back to the old value restarts the window from zero.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            w_cnt_nxt[k]   = '0;
            w_level_nxt[k] = r_level[k];
            w_pulse_nxt[k] = 1'b0;
            if (w_sync[k] != r_level[k]) begin
                if (r_cnt[k] == CNT_LAST) begin
                    w_level_nxt[k] = w_sync[k];
                    w_pulse_nxt[k] = w_sync[k] ? bus.edge_mode[2*k] : bus.edge_mode[2*k+1];
                end else begin
                    w_cnt_nxt[k] = r_cnt[k] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= INIT_LEVEL;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                r_cnt[k] <= '0;
            end
            r_level         <= INIT_LEVEL;
            r_pulse         <= '0;
            r_event         <= '0;
            r_capture       <= '0;
            r_capture_valid <= 1'b0;
        end else begin
            r_sync[0] <= bus.sig_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            for (int k = 0; k < CHANNELS; k++) begin
                r_cnt[k] <= w_cnt_nxt[k];
            end
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
            // Set beats clear when both land on the same edge.
            r_event <= w_pulse_nxt | (r_event & ~bus.clear_i);
            if (w_pulse_nxt[CAPTURE_CH]) begin
                r_capture       <= w_level_nxt;
                r_capture_valid <= 1'b1;
            end else begin
                r_capture_valid <= 1'b0;
            end
        end
    end

    assign bus.level_o       = r_level;
    assign bus.pulse_o       = r_pulse;
    assign bus.event_o       = r_event;
    assign bus.capture_o     = r_capture;
    assign bus.capture_valid = r_capture_valid;
endmodule

// File: tb/tb_input_frontend.sv
// tb/tb_input_frontend.sv - directed table-driven bench for input_frontend
module tb_input_frontend;
    logic clk;
    logic reset;

    input_frontend_if #(.CHANNELS(4)) bus ();

    input_frontend #(
        .CHANNELS        (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .INIT_LEVEL      (4'b0000),
        .CAPTURE_CH      (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic [3:0] sig;
        logic [7:0] mode;
        logic [3:0] clr;
        int         n;
        logic [3:0] lvl;
        logic [3:0] pul;
        logic [3:0] evt;
        logic [3:0] cap;
        logic       capv;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst, input logic [3:0] sig, input logic [7:0] mode,
                       input logic [3:0] clr, input int n, input logic [3:0] lvl,
                       input logic [3:0] pul, input logic [3:0] evt, input logic [3:0] cap,
                       input logic capv);
        vec_t v;
        v.rst = rst; v.sig = sig; v.mode = mode; v.clr = clr; v.n = n;
        v.lvl = lvl; v.pul = pul; v.evt = evt; v.cap = cap; v.capv = capv;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.sig_i     = 4'hF;
        bus.edge_mode = 8'hFF;
        bus.clear_i   = 4'h0;

        //   rst sig  mode   clr n   lvl  pul  evt  cap  capv
        add(1, 4'hF, 8'hFF, 4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'hF, 8'hFF, 4'h0, 5, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'hF, 8'hFF, 4'h0, 1, 4'hF, 4'hF, 4'hF, 4'hF, 1);
        add(0, 4'hF, 8'hFF, 4'h0, 1, 4'hF, 4'h0, 4'hF, 4'hF, 0);
        add(1, 4'h0, 8'hFF, 4'h0, 2, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h0, 8'hFF, 4'h0, 2, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        // short glitch then a held rise on channel 0
        add(0, 4'h1, 8'hFF, 4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h0, 8'hFF, 4'h0, 5, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h1, 8'hFF, 4'h0, 5, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h1, 8'hFF, 4'h0, 1, 4'h1, 4'h1, 4'h1, 4'h0, 0);
        add(0, 4'h1, 8'hFF, 4'h0, 1, 4'h1, 4'h0, 4'h1, 4'h0, 0);
        // channel 0 falling-only
        add(0, 4'h0, 8'hFE, 4'h0, 5, 4'h1, 4'h0, 4'h1, 4'h0, 0);
        add(0, 4'h0, 8'hFE, 4'h0, 1, 4'h0, 4'h1, 4'h1, 4'h0, 0);
        add(0, 4'h0, 8'hFE, 4'h1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h1, 8'hFE, 4'h0, 5, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h1, 8'hFE, 4'h0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h1, 8'hFE, 4'h0, 4, 4'h1, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h0, 8'hFE, 4'h0, 5, 4'h1, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h0, 8'hFE, 4'h0, 1, 4'h0, 4'h1, 4'h1, 4'h0, 0);
        add(0, 4'h0, 8'hFE, 4'h0, 4, 4'h0, 4'h0, 4'h1, 4'h0, 0);
        // set beats clear on channel 2
        add(0, 4'h4, 8'hFF, 4'h0, 5, 4'h0, 4'h0, 4'h1, 4'h0, 0);
        add(0, 4'h4, 8'hFF, 4'h0, 1, 4'h4, 4'h4, 4'h5, 4'h0, 0);
        add(0, 4'h0, 8'hFF, 4'h0, 5, 4'h4, 4'h0, 4'h5, 4'h0, 0);
        add(0, 4'h0, 8'hFF, 4'h4, 1, 4'h0, 4'h4, 4'h5, 4'h0, 0);
        add(0, 4'h0, 8'hFF, 4'h4, 1, 4'h0, 4'h0, 4'h1, 4'h0, 0);
        add(0, 4'h0, 8'hFF, 4'h1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        // capture on channel 3, including same-edge updates
        add(0, 4'h6, 8'hFF, 4'h0, 6, 4'h6, 4'h6, 4'h6, 4'h0, 0);
        add(0, 4'h6, 8'hFF, 4'h0, 1, 4'h6, 4'h0, 4'h6, 4'h0, 0);
        add(0, 4'hE, 8'hFF, 4'h0, 5, 4'h6, 4'h0, 4'h6, 4'h0, 0);
        add(0, 4'hE, 8'hFF, 4'h0, 1, 4'hE, 4'h8, 4'hE, 4'hE, 1);
        add(0, 4'hE, 8'hFF, 4'h0, 1, 4'hE, 4'h0, 4'hE, 4'hE, 0);
        add(0, 4'hF, 8'hFF, 4'h0, 6, 4'hF, 4'h1, 4'hF, 4'hE, 0);
        add(0, 4'hF, 8'hFF, 4'h0, 1, 4'hF, 4'h0, 4'hF, 4'hE, 0);
        add(0, 4'h6, 8'hFF, 4'h0, 6, 4'h6, 4'h9, 4'hF, 4'h6, 1);
        add(0, 4'h6, 8'hFF, 4'h0, 1, 4'h6, 4'h0, 4'hF, 4'h6, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            reset         = tbl[i].rst;
            bus.sig_i     = tbl[i].sig;
            bus.edge_mode = tbl[i].mode;
            bus.clear_i   = tbl[i].clr;
            repeat (tbl[i].n) step();
            chk("level",   i, 32'(bus.level_o),       32'(tbl[i].lvl));
            chk("pulse",   i, 32'(bus.pulse_o),       32'(tbl[i].pul));
            chk("event",   i, 32'(bus.event_o),       32'(tbl[i].evt));
            chk("capture", i, 32'(bus.capture_o),     32'(tbl[i].cap));
            chk("capv",    i, 32'(bus.capture_valid), 32'(tbl[i].capv));
        end

        // reset arriving mid-debounce throws the pending rise away
        reset         = 1'b1;
        bus.sig_i     = 4'h0;
        bus.edge_mode = 8'hFF;
        bus.clear_i   = 4'h0;
        repeat (2) step();
        reset = 1'b0;
        repeat (2) step();
        bus.sig_i = 4'b0010;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("abort_pre_level", i, 32'(bus.level_o), 32'h0);
        end
        reset = 1'b1;
        step();
        chk("abort_rst_level", 0, 32'(bus.level_o), 32'h0);
        chk("abort_rst_pulse", 0, 32'(bus.pulse_o), 32'h0);
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("abort_post_level", i, 32'(bus.level_o), (i == 6) ? 32'h2 : 32'h0);
            chk("abort_post_pulse", i, 32'(bus.pulse_o), (i == 6) ? 32'h2 : 32'h0);
        end
        step();
        chk("abort_tail_pulse", 7, 32'(bus.pulse_o), 32'h0);
        chk("abort_tail_event", 7, 32'(bus.event_o), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
